// File: rtl/gpc_pkg.sv
// gpc_pkg: shared definitions for the GPC(3,1,1,1;5) bit-heap stage.
//   - heap slice / compressed value widths
//   - column weight constants
//   - frame accumulator FSM state encoding
package gpc_pkg;

  localparam int GPC3111_IN_W  = 6;
  localparam int GPC3111_OUT_W = 5;

  localparam logic [GPC3111_OUT_W-1:0] W0 = 5'd1;
  localparam logic [GPC3111_OUT_W-1:0] W1 = 5'd2;
  localparam logic [GPC3111_OUT_W-1:0] W2 = 5'd4;
  localparam logic [GPC3111_OUT_W-1:0] W3 = 5'd8;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } heap_state_e;

endpackage

// File: rtl/gpc3111_5.sv
// gpc3111_5: generalized parallel counter (3,1,1,1;5).
// Compresses one 6-bit heap slice into its 5-bit weighted sum (0..31).
// Ports:
//   src0  in  1  heap bit, weight 1
//   src1  in  1  heap bit, weight 2
//   src2  in  1  heap bit, weight 4
//   src3  in  3  heap bits, weight 8 each
//   dst   out 5  weighted sum
module gpc3111_5
  import gpc_pkg::*;
(
  input  logic                     src0,
  input  logic                     src1,
  input  logic                     src2,
  input  logic [2:0]               src3,
  output logic [GPC3111_OUT_W-1:0] dst
);

  logic [GPC3111_IN_W-1:0] heap;
  logic [1:0]              col3_cnt;

  assign heap = {src3, src2, src1, src0};

  // Ones-count of the weight-8 column (0..3).
  assign col3_cnt = {1'b0, heap[3]} + {1'b0, heap[4]} + {1'b0, heap[5]};

  assign dst = (W0 & {GPC3111_OUT_W{heap[0]}})
             + (W1 & {GPC3111_OUT_W{heap[1]}})
             + (W2 & {GPC3111_OUT_W{heap[2]}})
             + (W3 * {3'b000, col3_cnt});

endmodule

// File: rtl/gpc3111_heap_accum.sv
// gpc3111_heap_accum: streaming frame accumulator behind a gpc3111_5.
// Each accepted beat is compressed to 0..31, registered (stage 1), then
// added into an ACC_W-bit accumulator (stage 2). After FRAME_LEN beats the
// frame sum is held on a valid/ready output until consumed.
//
// Optional build macro: GPC_HEAP_ACCUM_SAT_EN
//   defined   -> accumulator clamps at 2^ACC_W-1 on overflow
//   undefined -> accumulator wraps mod 2^ACC_W
//   out_ovf is sticky for the frame in both cases.
//
// Ports:
//   clk        in   1      clock
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      input beat valid
//   in_ready   out  1      beat accepted this cycle when in_valid
//   src0..2    in   1      heap bits, weights 1/2/4
//   src3       in   3      heap bits, weight 8 each
//   out_valid  out  1      frame result valid
//   out_ready  in   1      downstream accepts result
//   out_sum    out  ACC_W  frame sum
//   out_ovf    out  1      frame sum overflowed
//
// state | meaning
// ACCUM | accepting beats, counting toward FRAME_LEN
// DRAIN | last beat in stage 1, stage 2 absorbs it
// HOLD  | result presented, waiting for out_ready
module gpc3111_heap_accum
  import gpc_pkg::*;
#(
  parameter int ACC_W     = 12,
  parameter int FRAME_LEN = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             src0,
  input  logic             src1,
  input  logic             src2,
  input  logic [2:0]       src3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int               CNT_W     = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);

  heap_state_e              state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [ACC_W-1:0]         acc_q, acc_d;
  logic                     ovf_q, ovf_d;
  logic                     p_val_q;
  logic [GPC3111_OUT_W-1:0] p_w_q;

  logic [GPC3111_OUT_W-1:0] gpc_dst;
  logic [ACC_W:0]           sum_w;
  logic                     accept;
  logic                     consume;

  gpc3111_5 u_gpc (
    .src0 (src0),
    .src1 (src1),
    .src2 (src2),
    .src3 (src3),
    .dst  (gpc_dst)
  );

  assign in_ready  = (state_q == ACCUM) && !rst;
  assign out_valid = (state_q == HOLD);
  assign out_sum   = out_valid ? acc_q : '0;
  assign out_ovf   = out_valid & ovf_q;
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM: if (accept && (cnt_q == LAST_BEAT)) state_d = DRAIN;
      DRAIN: state_d = HOLD;
      HOLD:  if (out_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // One extra bit on the add exposes the carry that marks overflow.
  always_comb begin
    sum_w = {1'b0, acc_q} + {{(ACC_W + 1 - GPC3111_OUT_W){1'b0}}, p_w_q};
    acc_d = acc_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (consume) begin
      acc_d = '0;
      ovf_d = 1'b0;
      cnt_d = '0;
    end else begin
      if (accept) cnt_d = cnt_q + CNT_W'(1);
      if (p_val_q) begin
`ifdef GPC_HEAP_ACCUM_SAT_EN
        // Once clamped, any further carry re-clamps, so the value sticks.
        acc_d = sum_w[ACC_W] ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
`else
        acc_d = sum_w[ACC_W-1:0];
`endif
        ovf_d = ovf_q | sum_w[ACC_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      p_val_q <= 1'b0;
      p_w_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      p_val_q <= accept;
      if (accept) p_w_q <= gpc_dst;
    end
  end

endmodule

// File: tb/tb_gpc3111_heap_accum.sv
// Self-checking bench for gpc3111_heap_accum. Three instances:
//   dut0: ACC_W=12, FRAME_LEN=16  (main function, backpressure, reset)
//   dut1: ACC_W=8,  FRAME_LEN=16  (overflow, wrap or saturate)
//   dut2: ACC_W=12, FRAME_LEN=1   (single-beat exhaustive sweep)
module tb_gpc3111_heap_accum;

  logic       clk;
  logic [2:0] rst;
  logic [2:0] in_valid;
  logic [2:0] out_ready;
  logic [2:0] src0, src1, src2;
  logic [2:0] src3 [3];
  wire  [2:0] in_ready;
  wire  [2:0] out_valid;
  wire  [2:0] out_ovf;
  wire  [11:0] sum0;
  wire  [7:0]  sum1;
  wire  [11:0] sum2;

  int checks = 0;
  int errors = 0;

  gpc3111_heap_accum #(.ACC_W(12), .FRAME_LEN(16)) dut0 (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .src0(src0[0]), .src1(src1[0]), .src2(src2[0]), .src3(src3[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_sum(sum0), .out_ovf(out_ovf[0]));

  gpc3111_heap_accum #(.ACC_W(8), .FRAME_LEN(16)) dut1 (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .src0(src0[1]), .src1(src1[1]), .src2(src2[1]), .src3(src3[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_sum(sum1), .out_ovf(out_ovf[1]));

  gpc3111_heap_accum #(.ACC_W(12), .FRAME_LEN(1)) dut2 (
    .clk(clk), .rst(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .src0(src0[2]), .src1(src1[2]), .src2(src2[2]), .src3(src3[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_sum(sum2), .out_ovf(out_ovf[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] sum_of(input int k);
    case (k)
      0:       return sum0;
      1:       return {4'b0000, sum1};
      default: return sum2;
    endcase
  endfunction

  // Value of one heap slice straight from the column weights.
  function automatic int beat_val(input logic [5:0] v);
    return v[0] + 2 * v[1] + 4 * v[2] + 8 * (v[3] + v[4] + v[5]);
  endfunction

  // Frame result from the plain integer total of the frame.
  function automatic void model_frame(input int total, input int accw,
                                      output int s, output bit o);
    int maxv;
    maxv = (1 << accw) - 1;
    o = (total > maxv);
`ifdef GPC_HEAP_ACCUM_SAT_EN
    s = o ? maxv : total;
`else
    s = total % (maxv + 1);
`endif
  endfunction

  task automatic send_beat(input int k, input logic [5:0] v);
    int n;
    n = 0;
    @(negedge clk);
    in_valid[k] = 1'b1;
    src0[k] = v[0]; src1[k] = v[1]; src2[k] = v[2]; src3[k] = v[5:3];
    while (!in_ready[k] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[k]) begin
      checks++; errors++;
      $display("FAIL beat_accept dut%0d in_ready=%b required 1", k, in_ready[k]);
    end
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
  endtask

  task automatic wait_valid(input int k, input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid[k]) begin
      checks++; errors++;
      $display("FAIL %s_timeout dut%0d out_valid=%b required 1", nm, k, out_valid[k]);
    end
  endtask

  task automatic get_result(input int k, input int es, input bit eo, input string nm);
    wait_valid(k, nm);
    checks++;
    if (sum_of(k) !== 12'(es)) begin
      errors++;
      $display("FAIL %s_sum dut%0d got %0d required %0d", nm, k, sum_of(k), es);
    end
    checks++;
    if (out_ovf[k] !== eo) begin
      errors++;
      $display("FAIL %s_ovf dut%0d got %b required %b", nm, k, out_ovf[k], eo);
    end
    out_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[k] = 1'b0;
  endtask

  task automatic run_frame(input int k, input int n, input int accw, input bit rnd,
                           input logic [5:0] fixed, input int bub, input string nm);
    int total, es;
    bit eo;
    logic [5:0] v;
    total = 0;
    for (int i = 0; i < n; i++) begin
      v = rnd ? 6'($urandom_range(0, 63)) : fixed;
      send_beat(k, v);
      total += beat_val(v);
      if (bub > 0) repeat ($urandom_range(0, bub)) @(negedge clk);
    end
    model_frame(total, accw, es, eo);
    get_result(k, es, eo, nm);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (in_ready[k] !== 1'b0) begin
        errors++; $display("FAIL reset_in_ready dut%0d got %b required 0", k, in_ready[k]);
      end
      checks++;
      if (out_valid[k] !== 1'b0 || out_ovf[k] !== 1'b0 || sum_of(k) !== 12'd0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d valid=%b ovf=%b sum=%0d required 0 0 0",
                 k, out_valid[k], out_ovf[k], sum_of(k));
      end
    end
    rst = 3'b000;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (in_ready[k] !== 1'b1) begin
        errors++; $display("FAIL post_reset_in_ready dut%0d got %b required 1", k, in_ready[k]);
      end
    end
  endtask

  task automatic test_zero_frame;
    for (int i = 0; i < 16; i++) send_beat(0, 6'h00);
    @(negedge clk);
    checks++;
    if (out_valid[0] !== 1'b0) begin
      errors++; $display("FAIL zero_latency_early got %b required 0", out_valid[0]);
    end
    @(negedge clk);
    checks++;
    if (out_valid[0] !== 1'b1) begin
      errors++; $display("FAIL zero_latency_exact got %b required 1", out_valid[0]);
    end
    get_result(0, 0, 1'b0, "zero_frame");
  endtask

  task automatic test_full_frame;
    run_frame(0, 16, 12, 1'b0, 6'h3F, 0, "full_frame");
  endtask

  task automatic test_backpressure;
    int total, es;
    bit eo;
    logic [5:0] v;
    total = 0;
    for (int i = 0; i < 16; i++) begin
      v = 6'($urandom_range(0, 63));
      send_beat(0, v);
      total += beat_val(v);
      if (i[0]) @(negedge clk);
    end
    model_frame(total, 12, es, eo);
    wait_valid(0, "bp_hold");
    for (int c = 0; c < 5; c++) begin
      in_valid[0] = 1'b1;
      src0[0] = 1'b1; src1[0] = 1'b1; src2[0] = 1'b1; src3[0] = 3'b111;
      @(negedge clk);
      checks++;
      if (out_valid[0] !== 1'b1 || sum_of(0) !== 12'(es) || out_ovf[0] !== eo) begin
        errors++;
        $display("FAIL bp_stable cycle %0d valid=%b sum=%0d ovf=%b required 1 %0d %b",
                 c, out_valid[0], sum_of(0), out_ovf[0], es, eo);
      end
      checks++;
      if (in_ready[0] !== 1'b0) begin
        errors++; $display("FAIL bp_in_ready cycle %0d got %b required 0", c, in_ready[0]);
      end
    end
    in_valid[0] = 1'b0;
    get_result(0, es, eo, "bp_result");
    @(negedge clk);
    checks++;
    if (in_ready[0] !== 1'b1) begin
      errors++; $display("FAIL bp_recover_in_ready got %b required 1", in_ready[0]);
    end
    run_frame(0, 16, 12, 1'b1, 6'h00, 2, "bp_next_frame");
  endtask

  task automatic test_overflow;
    run_frame(1, 16, 8, 1'b0, 6'h3F, 0, "ovf_full");
    run_frame(1, 16, 8, 1'b0, 6'h00, 1, "ovf_clear");
    for (int f = 0; f < 4; f++) run_frame(1, 16, 8, 1'b1, 6'h00, 1, "ovf_random");
  endtask

  task automatic test_reset_mid_frame;
    for (int i = 0; i < 7; i++) send_beat(0, 6'h3F);
    @(negedge clk);
    rst[0] = 1'b1;
    #1;
    checks++;
    if (in_ready[0] !== 1'b0) begin
      errors++; $display("FAIL midrst_in_ready got %b required 0", in_ready[0]);
    end
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    run_frame(0, 16, 12, 1'b0, 6'h01, 0, "midrst_frame");
  endtask

  task automatic test_single_beat_sweep;
    for (int v = 0; v < 64; v++) begin
      send_beat(2, 6'(v));
      get_result(2, beat_val(6'(v)), 1'b0, "sweep");
    end
  endtask

  task automatic test_random_frames;
    for (int f = 0; f < 4; f++) run_frame(0, 16, 12, 1'b1, 6'h00, 3, "rand_frame");
  endtask

  initial begin
    rst = 3'b111;
    in_valid = '0;
    out_ready = '0;
    src0 = '0; src1 = '0; src2 = '0;
    for (int k = 0; k < 3; k++) src3[k] = 3'b000;
    test_reset;
    test_zero_frame;
    test_full_frame;
    test_backpressure;
    test_overflow;
    test_reset_mid_frame;
    test_single_beat_sweep;
    test_random_frames;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
